// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: bus width defaults and the
// 3-bit APB controller state encoding used by the bridge top and its blocks.
package apb_bridge_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_NSLV   = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_WRITE    = 3'd2,
        ST_WRITEP   = 3'd3,
        ST_WENABLE  = 3'd4,
        ST_WENABLEP = 3'd5,
        ST_READ     = 3'd6,
        ST_RENABLE  = 3'd7
    } apb_state_e;

    // States in which the APB access phase (penable high) is in progress.
    function automatic logic is_access_state(apb_state_e s);
        return (s == ST_RENABLE) || (s == ST_WENABLE) || (s == ST_WENABLEP);
    endfunction

endpackage

// File: rtl/apb_fsm_controller.sv
// APB back-end of the AHB-to-APB bridge: sequences setup/access phases and stalls
// the AHB master via hreadyout. Optional APB_PREADY_EN adds pready wait states.
module apb_fsm_controller
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W,
    parameter int NSLV   = APB_NSLV
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              valid,
    input  logic              hwrite,
    input  logic              hwritereg,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [ADDR_W-1:0] haddr1,
    input  logic [ADDR_W-1:0] haddr2,
    input  logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hwdata1,
    input  logic [NSLV-1:0]   temp_selx,
    input  logic [DATA_W-1:0] prdata,
`ifdef APB_PREADY_EN
    input  logic              pready,
`endif
    output logic [NSLV-1:0]   pselx,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              hreadyout,
    output logic [DATA_W-1:0] hrdata
);

    apb_state_e        state_q, state_d;
    logic [NSLV-1:0]   pselx_q, pselx_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              hreadyout_q, hreadyout_d;
    logic              stall;

    // A slave that is not ready freezes the access phase in place.
`ifdef APB_PREADY_EN
    assign stall = is_access_state(state_q) & ~pready;
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (valid && hwrite)       state_d = ST_WWAIT;
                else if (valid && !hwrite) state_d = ST_READ;
                else                       state_d = ST_IDLE;
            end
            ST_WWAIT:    state_d = valid ? ST_WRITEP : ST_WRITE;
            ST_WRITE:    state_d = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP:   state_d = ST_WENABLEP;
            ST_READ:     state_d = ST_RENABLE;
            ST_WENABLEP: begin
                if (!hwritereg) state_d = ST_READ;
                else if (valid) state_d = ST_WRITEP;
                else            state_d = ST_WRITE;
            end
            default:     state_d = ST_IDLE;
        endcase
        if (stall) state_d = state_q;
    end

    // Outputs are registered on the transition and keyed on the state being entered.
    always_comb begin
        pselx_d     = pselx_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        hreadyout_d = 1'b1;
        if (stall) begin
            hreadyout_d = 1'b0;
        end else begin
            case (state_d)
                ST_READ: begin
                    pselx_d     = temp_selx;
                    paddr_d     = (state_q == ST_WENABLEP) ? haddr1 : haddr;
                    pwrite_d    = 1'b0;
                    penable_d   = 1'b0;
                    hreadyout_d = 1'b0;
                end
                ST_WRITE, ST_WRITEP: begin
                    pselx_d     = temp_selx;
                    pwrite_d    = 1'b1;
                    penable_d   = 1'b0;
                    hreadyout_d = (state_d == ST_WRITE);
                    // Pipelined writes arrive one stage later than a fresh write.
                    if (state_q == ST_WENABLEP) begin
                        paddr_d  = haddr2;
                        pwdata_d = hwdata1;
                    end else begin
                        paddr_d  = haddr1;
                        pwdata_d = hwdata;
                    end
                end
                ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
                    penable_d = 1'b1;
                end
                default: begin
                    pselx_d   = '0;
                    penable_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= ST_IDLE;
            pselx_q     <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            hreadyout_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            hreadyout_q <= hreadyout_d;
        end
    end

    assign pselx     = pselx_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign hreadyout = hreadyout_q;
    assign hrdata    = prdata;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for apb_fsm_controller: vector table for reads/writes/bursts plus
// hand sequences for async reset and (with APB_PREADY_EN) pready wait states.
module tb_apb_fsm_controller;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        valid = 1'b0;
    logic        hwrite = 1'b0;
    logic        hwritereg = 1'b0;
    logic [31:0] haddr = '0, haddr1 = '0, haddr2 = '0;
    logic [31:0] hwdata = '0, hwdata1 = '0;
    logic [2:0]  temp_selx = '0;
    logic [31:0] prdata = '0;
`ifdef APB_PREADY_EN
    logic        pready = 1'b1;
`endif
    logic [2:0]  pselx;
    logic        penable, pwrite, hreadyout;
    logic [31:0] paddr, pwdata, hrdata;

    int errors = 0;
    int checks = 0;

    apb_fsm_controller #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) dut (
        .hclk(hclk), .hresetn(hresetn), .valid(valid), .hwrite(hwrite),
        .hwritereg(hwritereg), .haddr(haddr), .haddr1(haddr1), .haddr2(haddr2),
        .hwdata(hwdata), .hwdata1(hwdata1), .temp_selx(temp_selx), .prdata(prdata),
`ifdef APB_PREADY_EN
        .pready(pready),
`endif
        .pselx(pselx), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .hreadyout(hreadyout), .hrdata(hrdata)
    );

    always #5 hclk = ~hclk;

    // AHB slave-interface style delay line feeding the delayed inputs.
    always @(posedge hclk) begin
        haddr1    <= haddr;
        haddr2    <= haddr1;
        hwdata1   <= hwdata;
        hwritereg <= hwrite;
    end

    typedef struct {
        logic        valid;
        logic        hwrite;
        logic [31:0] haddr;
        logic [31:0] hwdata;
        logic [2:0]  sel;
        logic [31:0] prdata;
        logic [2:0]  e_sel;
        logic        e_pen;
        logic        e_pw;
        logic [31:0] e_paddr;
        logic [31:0] e_pwdata;
        logic        e_hr;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    function automatic vec_t mk(logic v, logic w, logic [31:0] a, logic [31:0] d,
                                logic [2:0] s, logic [31:0] rd, logic [2:0] es,
                                logic ep, logic ew, logic [31:0] ea, logic [31:0] ed,
                                logic eh);
        vec_t r;
        r.valid = v; r.hwrite = w; r.haddr = a; r.hwdata = d; r.sel = s; r.prdata = rd;
        r.e_sel = es; r.e_pen = ep; r.e_pw = ew; r.e_paddr = ea; r.e_pwdata = ed;
        r.e_hr = eh;
        return r;
    endfunction

    task automatic chk(input string name, input logic [2:0] es, input logic ep,
                       input logic ew, input logic [31:0] ea, input logic [31:0] ed,
                       input logic eh, input logic [31:0] erd);
        checks++;
        if (pselx !== es || penable !== ep || pwrite !== ew || paddr !== ea ||
            pwdata !== ed || hreadyout !== eh || hrdata !== erd) begin
            errors++;
            $display("FAIL %s: got sel=%b en=%b wr=%b addr=%h wdata=%h rdy=%b rdata=%h; want sel=%b en=%b wr=%b addr=%h wdata=%h rdy=%b rdata=%h",
                     name, pselx, penable, pwrite, paddr, pwdata, hreadyout, hrdata,
                     es, ep, ew, ea, ed, eh, erd);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] s, input logic [31:0] rd);
        valid = v; hwrite = w; haddr = a; hwdata = d; temp_selx = s; prdata = rd;
    endtask

    initial begin
        // single read, single write, 3-write burst, write then read
        vecs[0]  = mk(1,0,32'h8000_0010,32'h0,3'b001,32'h0,          3'b001,0,0,32'h8000_0010,32'h0,0);
        vecs[1]  = mk(0,0,32'h0,32'h0,3'b000,32'hDEAD_BEEF,           3'b001,1,0,32'h8000_0010,32'h0,1);
        vecs[2]  = mk(0,0,32'h0,32'h0,3'b000,32'h0,                   3'b000,0,0,32'h8000_0010,32'h0,1);
        vecs[3]  = mk(1,1,32'h8400_0020,32'h0,3'b010,32'h0,           3'b000,0,0,32'h8000_0010,32'h0,1);
        vecs[4]  = mk(0,0,32'h0,32'h1234_5678,3'b010,32'h0,           3'b010,0,1,32'h8400_0020,32'h1234_5678,1);
        vecs[5]  = mk(0,0,32'h0,32'h0,3'b000,32'h0,                   3'b010,1,1,32'h8400_0020,32'h1234_5678,1);
        vecs[6]  = mk(0,0,32'h0,32'h0,3'b000,32'h0,                   3'b000,0,1,32'h8400_0020,32'h1234_5678,1);
        vecs[7]  = mk(1,1,32'h8000_0000,32'h0,3'b001,32'h0,           3'b000,0,1,32'h8400_0020,32'h1234_5678,1);
        vecs[8]  = mk(1,1,32'h8000_0004,32'h1111_1111,3'b001,32'h0,   3'b001,0,1,32'h8000_0000,32'h1111_1111,0);
        vecs[9]  = mk(0,1,32'h8000_0008,32'h2222_2222,3'b001,32'h0,   3'b001,1,1,32'h8000_0000,32'h1111_1111,1);
        vecs[10] = mk(1,1,32'h8000_0008,32'h2222_2222,3'b001,32'h0,   3'b001,0,1,32'h8000_0004,32'h2222_2222,0);
        vecs[11] = mk(0,1,32'h8000_0008,32'h3333_3333,3'b001,32'h0,   3'b001,1,1,32'h8000_0004,32'h2222_2222,1);
        vecs[12] = mk(0,0,32'h0,32'h0,3'b001,32'h0,                   3'b001,0,1,32'h8000_0008,32'h3333_3333,1);
        vecs[13] = mk(0,0,32'h0,32'h0,3'b000,32'h0,                   3'b001,1,1,32'h8000_0008,32'h3333_3333,1);
        vecs[14] = mk(0,0,32'h0,32'h0,3'b000,32'h0,                   3'b000,0,1,32'h8000_0008,32'h3333_3333,1);
        vecs[15] = mk(1,1,32'h8000_0040,32'h0,3'b100,32'h0,           3'b000,0,1,32'h8000_0008,32'h3333_3333,1);
        vecs[16] = mk(1,0,32'h8000_0080,32'h55AA_55AA,3'b100,32'h0,   3'b100,0,1,32'h8000_0040,32'h55AA_55AA,0);
        vecs[17] = mk(0,0,32'h8000_0080,32'h0,3'b001,32'h0,           3'b100,1,1,32'h8000_0040,32'h55AA_55AA,1);
        vecs[18] = mk(0,0,32'h0,32'h0,3'b001,32'h0,                   3'b001,0,0,32'h8000_0080,32'h55AA_55AA,0);
        vecs[19] = mk(0,0,32'h0,32'h0,3'b000,32'hCAFE_F00D,           3'b001,1,0,32'h8000_0080,32'h55AA_55AA,1);
        vecs[20] = mk(0,0,32'h0,32'h0,3'b000,32'h0,                   3'b000,0,0,32'h8000_0080,32'h55AA_55AA,1);

        #12;
        chk("reset", 3'b000, 0, 0, 32'h0, 32'h0, 1, 32'h0);
        @(negedge hclk);
        hresetn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge hclk);
            drive(vecs[i].valid, vecs[i].hwrite, vecs[i].haddr, vecs[i].hwdata,
                  vecs[i].sel, vecs[i].prdata);
            @(posedge hclk);
            #2;
            chk($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_pen, vecs[i].e_pw,
                vecs[i].e_paddr, vecs[i].e_pwdata, vecs[i].e_hr, vecs[i].prdata);
        end

`ifdef APB_PREADY_EN
        // Read with two pready-low cycles in the access phase.
        @(negedge hclk); drive(1,0,32'h8000_0100,32'h0,3'b010,32'h0);
        @(posedge hclk); #2;
        chk("rdy_setup", 3'b010, 0, 0, 32'h8000_0100, 32'h55AA_55AA, 0, 32'h0);
        @(negedge hclk); drive(0,0,32'h0,32'h0,3'b000,32'h0); pready = 1'b0;
        @(posedge hclk); #2;
        chk("rdy_access", 3'b010, 1, 0, 32'h8000_0100, 32'h55AA_55AA, 1, 32'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge hclk); pready = 1'b0;
            @(posedge hclk); #2;
            chk($sformatf("rdy_wait%0d", k), 3'b010, 1, 0, 32'h8000_0100,
                32'h55AA_55AA, 0, 32'h0);
        end
        @(negedge hclk); pready = 1'b1; prdata = 32'h0BAD_F00D;
        @(posedge hclk); #2;
        chk("rdy_done", 3'b000, 0, 0, 32'h8000_0100, 32'h55AA_55AA, 1, 32'h0BAD_F00D);
`endif

        // Asynchronous reset in the middle of a write access phase.
        @(negedge hclk); drive(1,1,32'h8400_0020,32'h0,3'b010,32'h0);
        @(posedge hclk);
        @(negedge hclk); drive(0,0,32'h0,32'h9999_0000,3'b010,32'h0);
        @(posedge hclk);
        @(negedge hclk); drive(0,0,32'h0,32'h0,3'b000,32'h0);
        @(posedge hclk); #2;
        chk("rst_pre", 3'b010, 1, 1, 32'h8400_0020, 32'h9999_0000, 1, 32'h0);
        hresetn = 1'b0;
        #1;
        chk("rst_async", 3'b000, 0, 0, 32'h0, 32'h0, 1, 32'h0);
        @(negedge hclk);
        @(negedge hclk); hresetn = 1'b1;
        @(posedge hclk); #2;
        chk("rst_idle", 3'b000, 0, 0, 32'h0, 32'h0, 1, 32'h0);
        @(negedge hclk); drive(1,0,32'h8000_0010,32'h0,3'b001,32'h0);
        @(posedge hclk); #2;
        chk("rst_read", 3'b001, 0, 0, 32'h8000_0010, 32'h0, 0, 32'h0);
        @(negedge hclk); drive(0,0,32'h0,32'h0,3'b000,32'h0);
        @(posedge hclk); #2;
        chk("rst_renable", 3'b001, 1, 0, 32'h8000_0010, 32'h0, 1, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
